// File: rtl/regfile_pkg.sv
// Register file shared constants and types.
// Register-id and ROB-tag widths live here for every regfile file.
package regfile_pkg;

    localparam int REG_ID_BIT    = 5;
    localparam int ROB_WIDTH_BIT = 4;
    localparam int ROB_WIDTH     = 1 << ROB_WIDTH_BIT;
    localparam int NREG          = 1 << REG_ID_BIT;

    typedef logic [REG_ID_BIT-1:0]    reg_id_t;
    typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;

    typedef struct packed {
        logic    valid;
        reg_id_t rd;
        rob_id_t rob_id;
        logic [31:0] value;
    } commit_t;

endpackage

// File: rtl/regfile_if.sv
// One operand read port: architectural state in, resolved operand out.
// master = register file side, slave = operand selector.
interface regfile_if;
    import regfile_pkg::*;

    reg_id_t     rs;
    logic        busy;
    rob_id_t     tag;
    logic [31:0] reg_val;
    logic        rob_ready;
    logic [31:0] rob_value;
    logic        ready;
    logic [31:0] value;
    rob_id_t     dep;

    modport master (
        output rs, busy, tag, reg_val, rob_ready, rob_value,
        input  ready, value, dep
    );

    modport slave (
        input  rs, busy, tag, reg_val, rob_ready, rob_value,
        output ready, value, dep
    );

endinterface

// File: rtl/regfile_read_port.sv
// Operand selection for one source register.
// Order: x0, retiring producer, committed value, ROB result, pending.
module regfile_read_port
    import regfile_pkg::*;
(
    input  commit_t      cm_i,
    regfile_if.slave     p
);

    // pick the freshest final value, or report the producing tag
    always_comb begin
        p.ready = 1'b0;
        p.value = '0;
        p.dep   = '0;
        if (p.rs == '0) begin
            p.ready = 1'b1;
        end else if (cm_i.valid && cm_i.rd == p.rs &&
                     p.busy && p.tag == cm_i.rob_id) begin
            p.ready = 1'b1;
            p.value = cm_i.value;
        end else if (!p.busy) begin
            p.ready = 1'b1;
            p.value = p.reg_val;
        end else if (p.rob_ready) begin
            p.ready = 1'b1;
            p.value = p.rob_value;
        end else begin
            p.dep = p.tag;
        end
    end

endmodule

// File: rtl/regfile.sv
// Renaming register file: 32 values with busy bit and ROB tag each.
// Reads are combinational from pre-edge state; x0 is hardwired zero.
module regfile
    import regfile_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        issue_valid,
    input  reg_id_t     issue_rd,
    input  rob_id_t     issue_rob_id,
    input  reg_id_t     rs1,
    input  reg_id_t     rs2,
    output rob_id_t     reoder_1,
    output rob_id_t     reoder_2,
    input  logic        rob_rs1_is_ready,
    input  logic        rob_rs2_is_ready,
    input  logic [31:0] rob_rs1_value,
    input  logic [31:0] rob_rs2_value,
    output logic        rs1_ready,
    output logic        rs2_ready,
    output logic [31:0] rs1_value,
    output logic [31:0] rs2_value,
    output rob_id_t     rs1_dep,
    output rob_id_t     rs2_dep,
    input  logic        commit_valid,
    input  reg_id_t     commit_rd,
    input  rob_id_t     commit_rob_id,
    input  logic [31:0] commit_value,
    input  logic        flush
);

    logic [31:0]     val_q  [NREG];
    logic [31:0]     val_d  [NREG];
    rob_id_t         tag_q  [NREG];
    rob_id_t         tag_d  [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    commit_t cm;
    assign cm = '{valid: commit_valid, rd: commit_rd,
                  rob_id: commit_rob_id, value: commit_value};

    // commit writes value; issue renames afterwards so it wins
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (commit_valid && commit_rd != '0) begin
            val_d[commit_rd] = commit_value;
            if (tag_q[commit_rd] == commit_rob_id)
                busy_d[commit_rd] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (issue_valid && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_id;
        end
    end

    // state register; reset beats everything, rdy_in low holds
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    assign reoder_1 = tag_q[rs1];
    assign reoder_2 = tag_q[rs2];

    regfile_if p1 ();
    regfile_if p2 ();

    assign p1.rs        = rs1;
    assign p1.busy      = busy_q[rs1];
    assign p1.tag       = tag_q[rs1];
    assign p1.reg_val   = val_q[rs1];
    assign p1.rob_ready = rob_rs1_is_ready;
    assign p1.rob_value = rob_rs1_value;

    assign p2.rs        = rs2;
    assign p2.busy      = busy_q[rs2];
    assign p2.tag       = tag_q[rs2];
    assign p2.reg_val   = val_q[rs2];
    assign p2.rob_ready = rob_rs2_is_ready;
    assign p2.rob_value = rob_rs2_value;

    regfile_read_port u_rp1 (.cm_i(cm), .p(p1.slave));
    regfile_read_port u_rp2 (.cm_i(cm), .p(p2.slave));

    assign rs1_ready = p1.ready;
    assign rs1_value = p1.value;
    assign rs1_dep   = p1.dep;
    assign rs2_ready = p2.ready;
    assign rs2_value = p2.value;
    assign rs2_dep   = p2.dep;

endmodule
